zero_stream_core: RTL and testbench
===================================

Name: zero_stream_core

Overview:
- Clocked, parametrised executor for a subset of the Zero instruction set.
- Runs a program from an on-chip program memory against a local-memory array.
- Streams results through valid/ready output and input channels and reports completion status.
- Successor to the per-program combinational test harnesses: one core runs any loaded program, with backpressure, step limits and error reporting.

Parameters:
- W, 12, data/memory element width in bits.
- NLocal, 8, local memory words; LAW = clog2(NLocal).
- NProg, 32, program memory depth; PAW = clog2(NProg).
- MaxSteps, 1000, executed-instruction limit before timeout.
- IW, 6+LAW+2*W, instruction width (derived; not overridden).

Ports:
- clock  in  1  single clock, all logic posedge.
- reset  in  1  synchronous, active-low.
- prog_we  in  1  program write strobe.
- prog_addr  in  PAW  program write address.
- prog_data  in  IW  instruction word.
- start  in  1  begin execution at ip=0.
- in_valid  in  1  input word offered.
- in_data  in  W  input word.
- in_ready  out  1  core accepts input this cycle.
- out_valid  out  1  output word offered.
- out_data  out  W  output word.
- out_ready  in  1  sink accepts output.
- busy  out  1  program running.
- finished  out  1  program ended; held until next start.
- status  out  2  0=ok, 1=timeout, 2=illegal opcode.
- steps  out  clog2(MaxSteps+1)  executed-instruction count.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-low.
- Reset (reset=0 at posedge): all outputs 0, state IDLE, ip=0, steps=0, local memory cleared to 0. Program memory is not cleared.
- Instruction fields, MSB first:
  - op[3:0].
  - i1, i2: immediate flags.
  - t[LAW].
  - s1[W], s2[W].
- Operand value: immediate flag 1 gives the field value; flag 0 gives L[field[LAW-1:0]].
- Ops (op=value):
  - mov=0: L[t]=a.
  - not=1: L[t]=(a==0)?1:0.
  - add=2: L[t]=a+b mod 2^W.
  - sub=3: L[t]=a-b mod 2^W.
  - jmp=4: ip=a.
  - jeq=5: if L[t]==b, ip=a, else ip+1.
  - jne=6: if L[t]!=b, ip=a, else ip+1.
  - out=7: emit a.
  - in=8: L[t]=in_data.
  - halt=9.
  - 10..15: illegal.
- Jump targets use a[PAW-1:0].
- Program writes are accepted only when busy=0; prog_we while busy is ignored.
- States and transitions:
  - IDLE: start → FETCH, with ip=0, steps=0, finished=0, status=0, busy=1.
  - FETCH: synchronous program-memory read of ip → EXEC next cycle.
  - EXEC: execute the instruction and increment steps. Then:
    - out → OUTW;
    - in → INW;
    - halt → DONE (status 0);
    - illegal opcode → DONE (status 2);
    - otherwise → FETCH.
  - OUTW: out_valid=1, out_data=a. When out_valid&out_ready, transfer and → FETCH with ip+1. out_data stays stable while stalled.
  - INW: in_ready=1. When in_valid&in_ready, write L[t] and → FETCH with ip+1.
  - DONE: busy=0, finished=1. start → FETCH (restart; program and local memory retained).
- Latency: 2 cycles per ALU/jump instruction; out/in take ≥3 cycles.
- Run-off: next ip ≥ NProg (including ip=NProg-1 falling through) → DONE, status 0, equivalent to halt.
- Timeout: if steps reaches MaxSteps after an EXEC, → DONE with status 1. This applies even if the instruction was a jump. An out/in at that step still completes its handshake first.
- start while busy is ignored.
- Reset mid-run, including during OUTW with out_valid=1, aborts immediately: out_valid=0 on the next cycle, no transfer counted.
- Simultaneous source and target in one instruction (e.g. L[1]=L[1]+1): operands are read before the write.

Test Plan:
- Program: mov L0=#3; not L1=L0; not L2=L1; out L0; out L1; out L2; out_ready=1 → outputs 3,0,1 in order; finished=1, status=0, steps=6, run-off termination.
- Same program, out_ready low for 5 cycles at each output → out_data holds 3 stable while stalled; exactly 3 transfers; identical final state.
- Loop: mov L0=#0; add L0=L0+#1; jne L0!=#5 → ip1; out L0; halt → single output 5, steps=13, status 0.
- jmp #0 infinite loop with MaxSteps=20 → finished, status=1, steps=20.
- in L3, then out L3 with in_valid delayed 4 cycles and in_data=0xABC → output 0xABC; in_ready high only in INW.
- Opcode 12 at ip2 → status=2, steps=3. Then reset low mid-run of the loop program → all outputs 0 next cycle; a new start reruns cleanly.

Source files
------------

// File: rtl/zero_stream_core.sv
// Zero-subset executor: fetches from program memory, runs against local memory,
// and moves words through valid/ready out/in channels with step-limit supervision.
module zero_stream_core #(
  parameter int W        = 12,
  parameter int NLocal   = 8,
  parameter int NProg    = 32,
  parameter int MaxSteps = 1000,
  localparam int LAW = $clog2(NLocal),
  localparam int PAW = $clog2(NProg),
  localparam int IW  = 6 + LAW + 2*W,
  localparam int SW  = $clog2(MaxSteps+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [PAW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic [1:0]    status,
  output logic [SW-1:0] steps
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUTW, S_INW, S_DONE} state_t;

  localparam logic [PAW:0]  LAST = (PAW+1)'(NProg);
  localparam logic [SW-1:0] MAXS = SW'(MaxSteps);

  state_t         state_q, state_d;
  logic [PAW-1:0] ip_q, ip_d;
  logic [SW-1:0]  steps_q, steps_d, steps_inc;
  logic [1:0]     status_q, status_d;
  logic [W-1:0]   out_q, out_d;
  logic [IW-1:0]  ir_q;
  logic [IW-1:0]  pmem [NProg];
  logic [W-1:0]   lmem_q [NLocal];

  logic           lwe, io_fire;
  logic [W-1:0]   lwd;
  logic [PAW:0]   ip_inc, jtgt, nxt;

  logic [3:0]     op;
  logic           i1, i2;
  logic [LAW-1:0] t;
  logic [W-1:0]   s1, s2, a, b, lt;

  assign {op, i1, i2, t, s1, s2} = ir_q;
  // Operands come from the current (pre-write) local memory contents.
  assign a         = i1 ? s1 : lmem_q[s1[LAW-1:0]];
  assign b         = i2 ? s2 : lmem_q[s2[LAW-1:0]];
  assign lt        = lmem_q[t];
  assign ip_inc    = {1'b0, ip_q} + 1'b1;
  assign jtgt      = {1'b0, a[PAW-1:0]};
  assign steps_inc = steps_q + 1'b1;

  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                     (state_q == S_OUTW)  || (state_q == S_INW);
  assign finished  = (state_q == S_DONE);
  assign out_valid = (state_q == S_OUTW);
  assign in_ready  = (state_q == S_INW);
  assign out_data  = out_q;
  assign status    = status_q;
  assign steps     = steps_q;

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    steps_d  = steps_q;
    status_d = status_q;
    out_d    = out_q;
    lwe      = 1'b0;
    lwd      = '0;
    nxt      = ip_inc;
    io_fire  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d  = S_FETCH;
        ip_d     = '0;
        steps_d  = '0;
        status_d = 2'd0;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        steps_d = steps_inc;
        case (op)
          4'd0: begin lwe = 1'b1; lwd = a; end
          4'd1: begin lwe = 1'b1; lwd = {{(W-1){1'b0}}, a == '0}; end
          4'd2: begin lwe = 1'b1; lwd = a + b; end
          4'd3: begin lwe = 1'b1; lwd = a - b; end
          4'd4: nxt = jtgt;
          4'd5: if (lt == b) nxt = jtgt;
          4'd6: if (lt != b) nxt = jtgt;
          default: ;
        endcase
        if (op == 4'd7) begin
          out_d   = a;
          state_d = S_OUTW;
        end else if (op == 4'd8) begin
          state_d = S_INW;
        end else if (op > 4'd9) begin
          state_d  = S_DONE;
          status_d = 2'd2;
        end else if (steps_inc == MAXS) begin
          state_d  = S_DONE;
          status_d = 2'd1;
        end else if (op == 4'd9 || nxt >= LAST) begin
          state_d  = S_DONE;
          status_d = 2'd0;
        end else begin
          state_d = S_FETCH;
          ip_d    = nxt[PAW-1:0];
        end
      end
      S_OUTW: io_fire = out_ready;
      S_INW: if (in_valid) begin
        io_fire = 1'b1;
        lwe     = 1'b1;
        lwd     = in_data;
      end
      default: state_d = S_IDLE;
    endcase
    // A finished handshake still honours a step limit reached at its EXEC.
    if (io_fire) begin
      if (steps_q == MAXS) begin
        state_d  = S_DONE;
        status_d = 2'd1;
      end else if (ip_inc >= LAST) begin
        state_d  = S_DONE;
        status_d = 2'd0;
      end else begin
        state_d = S_FETCH;
        ip_d    = ip_inc[PAW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ip_q     <= '0;
      steps_q  <= '0;
      status_q <= 2'd0;
      out_q    <= '0;
      ir_q     <= '0;
      for (int i = 0; i < NLocal; i++) lmem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      steps_q  <= steps_d;
      status_q <= status_d;
      out_q    <= out_d;
      if (state_q == S_FETCH) ir_q <= pmem[ip_q];
      if (lwe) lmem_q[t] <= lwd;
    end
  end

  // Program memory survives reset; loads are locked out while running.
  always_ff @(posedge clock) begin
    if (prog_we && !busy && ({1'b0, prog_addr} < LAST)) pmem[prog_addr] <= prog_data;
  end
endmodule

// File: tb/tb_zero_stream_core.sv
// Directed bench for zero_stream_core: small programs with hand-computed results.
module tb_zero_stream_core;
  localparam int W = 12, NLocal = 8, NProg = 6, MaxSteps = 20;
  localparam int PAW = 3, IW = 33, SW = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           prog_we;
  logic [PAW-1:0] prog_addr;
  logic [IW-1:0]  prog_data;
  logic           start, in_valid, in_ready, out_valid, out_ready, busy, finished;
  logic [W-1:0]   in_data, out_data;
  logic [1:0]     status;
  logic [SW-1:0]  steps;

  zero_stream_core #(.W(W), .NLocal(NLocal), .NProg(NProg), .MaxSteps(MaxSteps)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .finished(finished), .status(status),
    .steps(steps)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] outs[$];
  int in_rdy_cyc, stall_bad, to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int i1, input int i2,
                                        input int t, input int s1, input int s2);
    return {op[3:0], i1[0], i2[0], t[2:0], s1[11:0], s2[11:0]};
  endfunction

  task automatic load(input int addr, input logic [IW-1:0] data);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = addr[PAW-1:0]; prog_data = data;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  // Start the loaded program and service both channels until it finishes.
  task automatic run(input int stall, input int idelay, input logic [W-1:0] idata,
                     input int budget, output int timed_out);
    int sc, ic, n;
    logic [W-1:0] hold;
    outs.delete(); in_rdy_cyc = 0; stall_bad = 0; sc = 0; ic = 0; n = 0; hold = '0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk("busy_after_start", busy, 1);
    out_ready = (stall == 0);
    while (!finished && n < budget) begin
      if (out_valid) begin
        if (sc == 0) hold = out_data;
        else if (out_data !== hold) stall_bad++;
        if (sc < stall) begin out_ready = 1'b0; sc++; end
        else begin out_ready = 1'b1; outs.push_back(out_data); sc = 0; end
      end else out_ready = (stall == 0);
      if (in_ready) begin
        in_rdy_cyc++;
        if (ic >= idelay) begin in_valid = 1'b1; in_data = idata; ic = 0; end
        else begin in_valid = 1'b0; ic++; end
      end else in_valid = 1'b0;
      @(negedge clock);
      n++;
    end
    in_valid = 1'b0;
    timed_out = (n >= budget);
  endtask

  initial begin
    int n;
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_status", status, 0);
    chk("rst_steps", steps, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;

    // mov/not/not then three outs; falls off the end of program memory.
    load(0, enc(0, 1, 0, 0, 3, 0));
    load(1, enc(1, 0, 0, 1, 0, 0));
    load(2, enc(1, 0, 0, 2, 1, 0));
    load(3, enc(7, 0, 0, 0, 0, 0));
    load(4, enc(7, 0, 0, 0, 1, 0));
    load(5, enc(7, 0, 0, 0, 2, 0));
    run(0, 0, '0, 200, to);
    chk("p1_timeout", to, 0);
    chk("p1_nout", outs.size(), 3);
    chk("p1_out0", outs[0], 12'd3);
    chk("p1_out1", outs[1], 12'd0);
    chk("p1_out2", outs[2], 12'd1);
    chk("p1_status", status, 0);
    chk("p1_steps", steps, 6);
    chk("p1_busy", busy, 0);
    chk("p1_in_ready_cycles", in_rdy_cyc, 0);
    repeat (3) @(negedge clock);
    chk("p1_finished_held", finished, 1);

    // Same program with a 5-cycle stall at each output.
    run(5, 0, '0, 300, to);
    chk("p1s_timeout", to, 0);
    chk("p1s_nout", outs.size(), 3);
    chk("p1s_out0", outs[0], 12'd3);
    chk("p1s_out1", outs[1], 12'd0);
    chk("p1s_out2", outs[2], 12'd1);
    chk("p1s_stable", stall_bad, 0);
    chk("p1s_status", status, 0);
    chk("p1s_steps", steps, 6);

    // Count L0 up to 5 with jne, emit it, halt.
    load(0, enc(0, 1, 0, 0, 0, 0));
    load(1, enc(2, 0, 1, 0, 0, 1));
    load(2, enc(6, 1, 1, 0, 1, 5));
    load(3, enc(7, 0, 0, 0, 0, 0));
    load(4, enc(9, 0, 0, 0, 0, 0));
    run(0, 0, '0, 200, to);
    chk("loop_timeout", to, 0);
    chk("loop_nout", outs.size(), 1);
    chk("loop_out0", outs[0], 12'd5);
    chk("loop_status", status, 0);
    chk("loop_steps", steps, 13);

    // jmp #0 forever: step limit ends it.
    load(0, enc(4, 1, 0, 0, 0, 0));
    run(0, 0, '0, 200, to);
    chk("jmp_timeout_bound", to, 0);
    chk("jmp_finished", finished, 1);
    chk("jmp_status", status, 1);
    chk("jmp_steps", steps, 20);
    chk("jmp_nout", outs.size(), 0);

    // in L3 with delayed in_valid, out L3, halt.
    load(0, enc(8, 0, 0, 3, 0, 0));
    load(1, enc(7, 0, 0, 0, 3, 0));
    load(2, enc(9, 0, 0, 0, 0, 0));
    run(0, 4, 12'hABC, 200, to);
    chk("in_timeout", to, 0);
    chk("in_nout", outs.size(), 1);
    chk("in_out0", outs[0], 12'hABC);
    chk("in_ready_cycles", in_rdy_cyc, 5);
    chk("in_status", status, 0);
    chk("in_steps", steps, 3);

    // Illegal opcode 12 at ip2.
    load(0, enc(0, 1, 0, 0, 1, 0));
    load(1, enc(0, 1, 0, 1, 2, 0));
    load(2, enc(12, 0, 0, 0, 0, 0));
    run(0, 0, '0, 200, to);
    chk("ill_timeout", to, 0);
    chk("ill_status", status, 2);
    chk("ill_steps", steps, 3);

    // Loop program, stalled at its output, then reset mid-OUTW.
    load(0, enc(0, 1, 0, 0, 0, 0));
    load(1, enc(2, 0, 1, 0, 0, 1));
    load(2, enc(6, 1, 1, 0, 1, 5));
    load(3, enc(7, 0, 0, 0, 0, 0));
    load(4, enc(9, 0, 0, 0, 0, 0));
    out_ready = 1'b0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      if (n == 2) begin prog_we = 1'b1; prog_addr = 3'd1; prog_data = enc(9, 0, 0, 0, 0, 0); end
      else prog_we = 1'b0;
      @(negedge clock);
      n++;
    end
    prog_we = 1'b0;
    chk("mr_reached_outw", out_valid, 1);
    chk("mr_out_data", out_data, 12'd5);
    reset = 1'b0;
    @(negedge clock);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_finished", finished, 0);
    chk("mr_status", status, 0);
    chk("mr_steps", steps, 0);
    chk("mr_out_data_clr", out_data, 0);
    reset = 1'b1;
    @(negedge clock);
    run(0, 0, '0, 200, to);
    chk("rerun_timeout", to, 0);
    chk("rerun_nout", outs.size(), 1);
    chk("rerun_out0", outs[0], 12'd5);
    chk("rerun_status", status, 0);
    chk("rerun_steps", steps, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
